// File: rtl/uart_tx_out_port_if.sv
// Processor-side bundle for the UART output port: output word in, status word and serial line out.
// master drives OutWord; slave (the port) drives StatusWord and TxD.
interface uart_tx_out_port_if #(
  parameter int dataW = 32
);
  logic [dataW-1:0] OutWord;
  logic [dataW-1:0] StatusWord;
  logic             TxD;

  modport master (
    output OutWord,
    input  StatusWord,
    input  TxD
  );

  modport slave (
    input  OutWord,
    output StatusWord,
    output TxD
  );
endinterface

// File: rtl/uart_tx_out_port.sv
// Toggle-triggered byte FIFO feeding an 8N1 UART transmitter, with polled status word.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_out_port #(
  parameter int dataW     = 32,
  parameter int ClkPerBit = 868,
  parameter int FifoDepth = 8
) (
  input logic                clock,
  input logic                reset,
  uart_tx_out_port_if.slave  bus
);
  localparam int CW = $clog2(FifoDepth + 1);
  localparam int PW = $clog2(FifoDepth);
  localparam int TW = $clog2(ClkPerBit);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;

  state_t         state_q, state_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [2:0]     bit_idx_q, bit_idx_d;
  logic [7:0]     shift_q, shift_d;
  logic           txd_q, txd_d;
  logic           prev_q, prev_d;
  logic           ovf_q, ovf_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]  wr_q, wr_d;
  logic [PW-1:0]  rd_q, rd_d;
  logic [dataW-1:0] status_q, status_d;
  logic [7:0]     mem [FifoDepth];
`ifdef UART_TX_PARITY_EN
  logic           par_q, par_d;
`endif

  logic toggle, push, pop, full, accept, drop, tick;
  logic [7:0] head;
  logic unused_hi;

  assign unused_hi = ^bus.OutWord[dataW-1:10];
  assign toggle = bus.OutWord[8];
  assign head   = mem[rd_q];
  assign tick   = (timer_q == TW'(ClkPerBit - 1));

  // FIFO bookkeeping: toggle-edge push, pop on idle, sticky overflow
  always_comb begin
    push   = (toggle != prev_q);
    pop    = (state_q == IDLE) && (cnt_q != '0);
    full   = (cnt_q == CW'(FifoDepth));
    accept = push && (!full || pop);
    drop   = push && !accept;
    prev_d = toggle;
    ovf_d  = ovf_q;
    if (drop)
      ovf_d = 1'b1;
    else if (bus.OutWord[9])
      ovf_d = 1'b0;
    wr_d = accept ? wr_q + PW'(1) : wr_q;
    rd_d = pop ? rd_q + PW'(1) : rd_q;
    cnt_d = cnt_q;
    if (accept && !pop)
      cnt_d = cnt_q + CW'(1);
    else if (pop && !accept)
      cnt_d = cnt_q - CW'(1);
  end

  // serial framer: start, 8 data bits LSB first, optional parity, stop
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    txd_d     = txd_q;
`ifdef UART_TX_PARITY_EN
    par_d     = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        txd_d = 1'b1;
        if (pop) begin
          shift_d   = head;
`ifdef UART_TX_PARITY_EN
          par_d     = ^head;
`endif
          timer_d   = '0;
          bit_idx_d = '0;
          state_d   = START;
          txd_d     = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          timer_d = '0;
          state_d = DATA;
          txd_d   = shift_q[0];
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      DATA: begin
        if (tick) begin
          timer_d = '0;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            txd_d   = par_q;
`else
            state_d = STOP;
            txd_d   = 1'b1;
`endif
          end else begin
            shift_d   = shift_q >> 1;
            bit_idx_d = bit_idx_q + 3'd1;
            txd_d     = shift_q[1];
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) begin
          timer_d = '0;
          state_d = STOP;
          txd_d   = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
`endif
      STOP: begin
        if (tick) begin
          timer_d = '0;
          state_d = IDLE;
          txd_d   = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

  // status word reflects the post-edge FIFO and framer state
  always_comb begin
    status_d       = '0;
    status_d[0]    = (cnt_d == CW'(FifoDepth));
    status_d[1]    = (cnt_d == '0);
    status_d[2]    = (state_d != IDLE);
    status_d[3]    = ovf_d;
    status_d[15:8] = 8'(cnt_d);
  end

  // FIFO storage needs no reset; the pointers define validity
  always_ff @(posedge clock) begin
    if (accept)
      mem[wr_q] <= bus.OutWord[7:0];
  end

  // state registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      txd_q     <= 1'b1;
      prev_q    <= 1'b0;
      ovf_q     <= 1'b0;
      cnt_q     <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      status_q  <= dataW'(2);
`ifdef UART_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      txd_q     <= txd_d;
      prev_q    <= prev_d;
      ovf_q     <= ovf_d;
      cnt_q     <= cnt_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      status_q  <= status_d;
`ifdef UART_TX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  assign bus.StatusWord = status_q;
  assign bus.TxD        = txd_q;
endmodule
